// File: rtl/chan_frame_serializer_pkg.sv
// Shared definitions for the channel frame serializer: parameter defaults,
// control-FSM state encoding and an address-width helper.
package chan_frame_serializer_pkg;

    localparam int DEF_CHANNELS     = 32;
    localparam int DEF_CHANNELS_PW2 = 7;
    localparam int DEF_DATA_WIDTH   = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Bits needed to address n bank entries (at least one).
    function automatic int addr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chan_frame_bank.sv
// Ping-pong sample storage: two banks of CHANNELS samples, one synchronous
// write port and one asynchronous read port.
module chan_frame_bank
    import chan_frame_serializer_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int AW         = addr_bits(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_bank,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2][CHANNELS];

    // NOTE: storage has no reset so it maps onto plain RAM; unwritten entries read stale data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/chan_frame_serializer.sv
// Collects one frame of randomly ordered channel samples into a ping-pong
// buffer and replays it in channel order on the valid/read sample stream.
module chan_frame_serializer
    import chan_frame_serializer_pkg::*;
#(
    parameter int CHANNELS     = DEF_CHANNELS,
    parameter int CHANNELS_PW2 = DEF_CHANNELS_PW2,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   wr_sample,
    input  logic [CHANNELS_PW2-1:0] wr_num,
    input  logic                    wr_en,
    input  logic                    frame_done,
    output logic [DATA_WIDTH-1:0]   chan_out_sample,
    output logic [CHANNELS_PW2-1:0] chan_out_num,
    output logic                    chan_out_valid,
    input  logic                    chan_out_read,
    output logic                    overflow,
    input  logic                    clear_overflow,
    output logic                    busy
);

    localparam int AW = addr_bits(CHANNELS);
    localparam logic [CHANNELS_PW2-1:0] LAST_IDX  = CHANNELS_PW2'(CHANNELS - 1);
    localparam logic [CHANNELS_PW2:0]   NUM_LIMIT = (CHANNELS_PW2 + 1)'(CHANNELS);

    state_t                  state, state_n;
    logic                    wbank, wbank_n;
    logic                    rbank, rbank_n;
    logic                    pending, pending_n;
    logic [CHANNELS_PW2-1:0] idx, idx_n;
    logic                    valid_n;
    logic                    load;
    logic                    ovf_set;
    logic                    wr_ok;
    logic                    xfer;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [DATA_WIDTH-1:0]   load_data;

    chan_frame_bank #(
        .CHANNELS   (CHANNELS),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_bank (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_bank (wbank),
        .wr_addr (wr_num[AW-1:0]),
        .wr_data (wr_sample),
        .rd_bank (rbank_n),
        .rd_addr (idx_n[AW-1:0]),
        .rd_data (rd_data)
    );

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_n   = state;
        wbank_n   = wbank;
        rbank_n   = rbank;
        pending_n = pending;
        idx_n     = idx;
        valid_n   = chan_out_valid;
        load      = 1'b0;
        wr_ok     = wr_en && ({1'b0, wr_num} < NUM_LIMIT) && !pending;
        ovf_set   = wr_en && pending;
        xfer      = chan_out_valid && chan_out_read;

        case (state)
            ST_IDLE: begin
                if (frame_done) begin
                    rbank_n = wbank;
                    wbank_n = ~wbank;
                    idx_n   = '0;
                    valid_n = 1'b1;
                    load    = 1'b1;
                    state_n = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xfer && idx == LAST_IDX) begin
                    if (pending) begin
                        // Swap without a bubble; a frame_done now closes the freed bank.
                        rbank_n   = wbank;
                        wbank_n   = rbank;
                        idx_n     = '0;
                        load      = 1'b1;
                        pending_n = frame_done;
                    end else if (frame_done) begin
                        rbank_n = wbank;
                        wbank_n = ~wbank;
                        idx_n   = '0;
                        load    = 1'b1;
                    end else begin
                        valid_n = 1'b0;
                        state_n = ST_IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idx_n = idx + 1'b1;
                        load  = 1'b1;
                    end
                    if (frame_done) begin
                        if (pending) begin
                            ovf_set = 1'b1;
                        end else begin
                            pending_n = 1'b1;
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // A sample written in the cycle its frame starts is not in the bank yet.
        if (wr_ok && wbank == rbank_n && wr_num == idx_n) begin
            load_data = wr_sample;
        end else begin
            load_data = rd_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            wbank           <= 1'b0;
            rbank           <= 1'b0;
            pending         <= 1'b0;
            idx             <= '0;
            chan_out_valid  <= 1'b0;
            chan_out_sample <= '0;
            overflow        <= 1'b0;
        end else begin
            state          <= state_n;
            wbank          <= wbank_n;
            rbank          <= rbank_n;
            pending        <= pending_n;
            idx            <= idx_n;
            chan_out_valid <= valid_n;
            if (load) begin
                chan_out_sample <= load_data;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign chan_out_num = idx;
    assign busy         = (state == ST_STREAM) || pending;

endmodule

// File: tb/tb_chan_frame_serializer.sv
// Bench for chan_frame_serializer: vector table, directed corner sequences and
// a randomized run against a frame-queue reference model.
module tb_chan_frame_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] wr_sample;
    logic [6:0]  wr_num;
    logic        wr_en;
    logic        frame_done;
    logic [15:0] chan_out_sample;
    logic [6:0]  chan_out_num;
    logic        chan_out_valid;
    logic        chan_out_read;
    logic        overflow;
    logic        clear_overflow;
    logic        busy;

    int total = 0;
    int bad   = 0;

    chan_frame_serializer #(
        .CHANNELS     (32),
        .CHANNELS_PW2 (7),
        .DATA_WIDTH   (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .wr_sample       (wr_sample),
        .wr_num          (wr_num),
        .wr_en           (wr_en),
        .frame_done      (frame_done),
        .chan_out_sample (chan_out_sample),
        .chan_out_num    (chan_out_num),
        .chan_out_valid  (chan_out_valid),
        .chan_out_read   (chan_out_read),
        .overflow        (overflow),
        .clear_overflow  (clear_overflow),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [6:0]  wr_num;
        logic [15:0] wr_sample;
        logic        frame_done;
        logic        read;
        logic        clr;
        logic        exp_valid;
        logic [6:0]  exp_num;
        logic [15:0] exp_sample;
        logic        exp_busy;
        logic        exp_ovf;
    } vec_t;

    typedef struct packed {
        logic [6:0]  num;
        logic [15:0] smp;
    } word_t;

    vec_t  vecs[$];
    word_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [6:0] n, input logic [15:0] s);
        check({tag, "_valid"}, 32'(chan_out_valid), 32'(v));
        if (v) begin
            check({tag, "_num"}, 32'(chan_out_num), 32'(n));
            check({tag, "_sample"}, 32'(chan_out_sample), 32'(s));
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, sample 1 ns later.
    task automatic cyc(input logic we, input logic [6:0] n, input logic [15:0] s,
                       input logic fd, input logic rd, input logic clr);
        wr_en          = we;
        wr_num         = n;
        wr_sample      = s;
        frame_done     = fd;
        chan_out_read  = rd;
        clear_overflow = clr;
        @(posedge clk);
        #1;
        wr_en          = 1'b0;
        frame_done     = 1'b0;
        chan_out_read  = 1'b0;
        clear_overflow = 1'b0;
    endtask

    function automatic vec_t mk(input logic we, input logic [6:0] n, input logic [15:0] s,
                                input logic fd, input logic rd, input logic clr,
                                input logic ev, input logic [6:0] en, input logic [15:0] es,
                                input logic eb, input logic eo);
        vec_t v;
        v.wr_en = we; v.wr_num = n; v.wr_sample = s; v.frame_done = fd;
        v.read = rd; v.clr = clr; v.exp_valid = ev; v.exp_num = en;
        v.exp_sample = es; v.exp_busy = eb; v.exp_ovf = eo;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int reads[$];
        int n;
        logic [15:0] wf[32];
        logic [31:0] wmask;

        reset = 1'b0;
        wr_en = 1'b0; wr_num = '0; wr_sample = '0; frame_done = 1'b0;
        chan_out_read = 1'b0; clear_overflow = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(chan_out_valid), 0);
        check("rst_num", 32'(chan_out_num), 0);
        check("rst_sample", 32'(chan_out_sample), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(overflow), 0);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);

        // ---------------- vector table: fill, ignore out-of-range, stream with back-pressure ----------------
        vecs.push_back(mk(1, 0, 16'h0100, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 7'd32, 16'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int ch = 1; ch < 31; ch++)
            vecs.push_back(mk(1, 7'(ch), 16'h0100 + 16'(ch), 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 7'd31, 16'h011F, 1, 0, 0, 1, 0, 16'h0100, 1, 0));
        reads = '{1, 0, 0, 1};
        for (int i = 0; i < 30; i++) reads.push_back(1);
        reads.push_back(0);
        e = 0;
        foreach (reads[i]) begin
            if (reads[i] != 0 && e < 32) e++;
            vecs.push_back(mk(0, 0, 0, 0, 1'(reads[i]), 0, e < 32, 7'(e), 16'h0100 + 16'(e), e < 32, 0));
        end
        foreach (vecs[i]) begin
            cyc(vecs[i].wr_en, vecs[i].wr_num, vecs[i].wr_sample, vecs[i].frame_done, vecs[i].read, vecs[i].clr);
            expect_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_num, vecs[i].exp_sample);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
        end

        // ---------------- back-to-back frames, third frame dropped ----------------
        for (int ch = 0; ch < 32; ch++) cyc(1, 7'(ch), 16'hA000 + 16'(ch), ch == 31, 0, 0);
        expect_out("a_start", 1, 0, 16'hA000);
        for (int ch = 0; ch < 32; ch++) cyc(1, 7'(ch), 16'hB000 + 16'(ch), ch == 31, 0, 0);
        expect_out("a_held", 1, 0, 16'hA000);
        check("b_pend_busy", 32'(busy), 1);
        check("b_pend_ovf", 32'(overflow), 0);
        cyc(0, 0, 0, 1, 0, 0);
        check("third_fd_ovf", 32'(overflow), 1);
        cyc(1, 7'd5, 16'hC005, 0, 0, 0);
        for (int k = 1; k <= 64; k++) begin
            cyc(0, 0, 0, 0, 1, 0);
            if (k < 32) expect_out($sformatf("a%0d", k), 1, 7'(k), 16'hA000 + 16'(k));
            else if (k < 64) expect_out($sformatf("b%0d", k - 32), 1, 7'(k - 32), 16'hB000 + 16'(k - 32));
            else expect_out("ab_end", 0, 0, 0);
            check($sformatf("ab_busy%0d", k), 32'(busy), 32'(k < 64));
        end
        check("ovf_sticky", 32'(overflow), 1);
        cyc(0, 0, 0, 0, 0, 1);
        check("ovf_clear", 32'(overflow), 0);

        // ---------------- set beats clear in the same cycle ----------------
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        check("setclr_pre", 32'(overflow), 0);
        cyc(0, 0, 0, 1, 0, 1);
        check("setclr_same", 32'(overflow), 1);
        cyc(0, 0, 0, 0, 0, 1);
        check("setclr_after", 32'(overflow), 0);
        n = 0;
        while (chan_out_valid && n < 200) begin
            cyc(0, 0, 0, 0, 1, 0);
            n++;
        end
        check("drain1_valid", 32'(chan_out_valid), 0);
        check("drain1_busy", 32'(busy), 0);

        // ---------------- async reset mid-stream ----------------
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        check("t6_ovf_set", 32'(overflow), 1);
        n = 0;
        while (chan_out_num != 7'd10 && n < 100) begin
            cyc(0, 0, 0, 0, 1, 0);
            n++;
        end
        check("t6_at_ch10", 32'(chan_out_num), 10);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_valid", 32'(chan_out_valid), 0);
        check("t6_async_busy", 32'(busy), 0);
        check("t6_async_ovf", 32'(overflow), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int ch = 0; ch < 32; ch++) cyc(1, 7'(ch), 16'h6000 + 16'(ch), ch == 31, 0, 0);
        for (int k = 0; k < 32; k++) begin
            expect_out($sformatf("t6_ch%0d", k), 1, 7'(k), 16'h6000 + 16'(k));
            cyc(0, 0, 0, 0, 1, 0);
        end
        expect_out("t6_end", 0, 0, 0);

        // ---------------- randomized run against the frame-queue model ----------------
        wmask = '0;
        foreach (wf[i]) wf[i] = '0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            int in_flight;
            logic we, fd, rd;
            logic [6:0] num;
            logic [15:0] smp;
            int r;
            int ch;
            in_flight = (q.size() + 31) / 32;
            check("rnd_valid", 32'(chan_out_valid), 32'(q.size() != 0));
            check("rnd_busy", 32'(busy), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("rnd_num", 32'(chan_out_num), 32'(q[0].num));
                check("rnd_sample", 32'(chan_out_sample), 32'(q[0].smp));
            end
            we = 0; fd = 0; num = '0; smp = '0;
            rd = ($urandom_range(0, 9) < 7);
            if (in_flight < 2) begin
                r = $urandom_range(0, 9);
                if (r < 6) begin
                    ch  = $urandom_range(0, 31);
                    smp = 16'($urandom);
                    num = 7'(ch);
                    we  = 1;
                    wf[ch] = smp;
                    wmask[ch] = 1'b1;
                end else if (r == 6) begin
                    num = 7'($urandom_range(32, 127));
                    smp = 16'($urandom);
                    we  = 1;
                end
                if (&wmask && $urandom_range(0, 3) == 0) fd = 1;
            end
            if (rd && q.size() != 0) void'(q.pop_front());
            if (fd) begin
                for (int k = 0; k < 32; k++) q.push_back(word_t'{7'(k), wf[k]});
                wmask = '0;
            end
            cyc(we, num, smp, fd, rd, 0);
        end
        n = 0;
        while (q.size() != 0 && n < 300) begin
            check("drain_valid", 32'(chan_out_valid), 1);
            check("drain_num", 32'(chan_out_num), 32'(q[0].num));
            check("drain_sample", 32'(chan_out_sample), 32'(q[0].smp));
            void'(q.pop_front());
            cyc(0, 0, 0, 0, 1, 0);
            n++;
        end
        check("rnd_final_valid", 32'(chan_out_valid), 0);
        check("rnd_final_busy", 32'(busy), 0);
        check("rnd_final_ovf", 32'(overflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
